// File: rtl/ifmap_double_buffer_pkg.sv
// ifmap_double_buffer_pkg: default widths and the bank-index encoding shared by the ifmap buffer files
package ifmap_double_buffer_pkg;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_BANK_ADDR_WIDTH = 8;
  typedef enum logic {BANK0 = 1'b0, BANK1 = 1'b1} bank_e;
endpackage

// File: rtl/ifmap_bank_ram.sv
// ifmap_bank_ram: one bank, sync write port (we/wadr/wdata) and registered read port (re/radr -> rdata, 1-cycle latency, holds when re=0)
module ifmap_bank_ram #(
  parameter int DW = 64,
  parameter int AW = 8,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wadr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] radr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[wadr] <= wdata;
    if (re) rdata <= mem[radr];
  end
endmodule

// File: rtl/ifmap_double_buffer.sv
// ifmap_double_buffer: ping-pong ifmap buffer; clk/rst_n, switch_banks swaps banks, ren/radr -> rdata/rdata_valid from rd_bank, wen/wadr/wdata into ~rd_bank, wr_count counts accepted writes
module ifmap_double_buffer
  import ifmap_double_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BANK_ADDR_WIDTH = DEF_BANK_ADDR_WIDTH,
  parameter int BANK_DEPTH = 2 ** BANK_ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     switch_banks,
  input  logic                     ren,
  input  logic [BANK_ADDR_WIDTH-1:0] radr,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     rdata_valid,
  input  logic                     wen,
  input  logic [BANK_ADDR_WIDTH-1:0] wadr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  output logic                     rd_bank,
  output logic [BANK_ADDR_WIDTH:0] wr_count
);
  localparam logic [BANK_ADDR_WIDTH:0] DEPTH_W = (BANK_ADDR_WIDTH + 1)'(BANK_DEPTH);
  localparam logic [BANK_ADDR_WIDTH:0] CNT_MAX = {1'b1, {BANK_ADDR_WIDTH{1'b0}}};
  bank_e rd_bank_q;
  logic w_ok, r_ok, zero_q, sel_q;
  logic [1:0] we, re;
  logic [DATA_WIDTH-1:0] bank_rdata [2];
  assign w_ok = rst_n && wen && ({1'b0, wadr} < DEPTH_W);
  assign r_ok = rst_n && ren && ({1'b0, radr} < DEPTH_W);
  assign we = {w_ok && rd_bank_q == BANK0, w_ok && rd_bank_q == BANK1};
  assign re = {r_ok && rd_bank_q == BANK1, r_ok && rd_bank_q == BANK0};
  for (genvar b = 0; b < 2; b++) begin : g_bank
    ifmap_bank_ram #(.DW(DATA_WIDTH), .AW(BANK_ADDR_WIDTH), .DEPTH(BANK_DEPTH)) u_ram (
      .clk,
      .we(we[b]),
      .wadr,
      .wdata,
      .re(re[b]),
      .radr,
      .rdata(bank_rdata[b])
    );
  end
  // zero_q forces 0 after reset and for out-of-range reads; sel_q remembers which bank the held word came from
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_bank_q <= BANK0;
      rdata_valid <= 1'b0;
      zero_q <= 1'b1;
      sel_q <= 1'b0;
      wr_count <= '0;
    end else begin
      if (switch_banks) rd_bank_q <= bank_e'(~rd_bank_q);
      rdata_valid <= ren;
      if (ren) begin
        zero_q <= !r_ok;
        sel_q <= rd_bank_q;
      end
      wr_count <= switch_banks ? '0 : (w_ok && wr_count != CNT_MAX) ? wr_count + 1'b1 : wr_count;
    end
  end
  assign rdata = zero_q ? '0 : bank_rdata[sel_q];
  assign rd_bank = rd_bank_q;
endmodule

// File: tb/tb_ifmap_double_buffer.sv
// tb_ifmap_double_buffer: table-driven check of the ping-pong ifmap buffer plus a wr_count saturation sequence
module tb_ifmap_double_buffer;
  localparam int DW = 64;
  localparam int AW = 8;
  localparam int DEPTH = 200;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic switch_banks = 1'b0;
  logic ren = 1'b0;
  logic wen = 1'b0;
  logic [AW-1:0] radr = '0;
  logic [AW-1:0] wadr = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic rdata_valid, rd_bank;
  logic [AW:0] wr_count;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic          rst_n, sw, ren;
    logic [AW-1:0] radr;
    logic          wen;
    logic [AW-1:0] wadr;
    logic [DW-1:0] wdata;
    logic          e_bank;
    logic [DW-1:0] e_rdata;
    logic          e_valid;
    logic [AW:0]   e_cnt;
  } vec_t;
  vec_t vecs[$];
  ifmap_double_buffer #(.DATA_WIDTH(DW), .BANK_ADDR_WIDTH(AW), .BANK_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .switch_banks(switch_banks),
    .ren(ren),
    .radr(radr),
    .rdata(rdata),
    .rdata_valid(rdata_valid),
    .wen(wen),
    .wadr(wadr),
    .wdata(wdata),
    .rd_bank(rd_bank),
    .wr_count(wr_count)
  );
  always #5 clk = ~clk;
  function automatic void add(input int r, sw, re, ra, we, wa, input longint wd,
                              input int eb, input longint ed, input int ev, ec);
    vec_t v;
    v.rst_n = r[0];
    v.sw = sw[0];
    v.ren = re[0];
    v.radr = AW'(ra);
    v.wen = we[0];
    v.wadr = AW'(wa);
    v.wdata = DW'(wd);
    v.e_bank = eb[0];
    v.e_rdata = DW'(ed);
    v.e_valid = ev[0];
    v.e_cnt = (AW + 1)'(ec);
    vecs.push_back(v);
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  initial begin
    int exp_cnt;
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) add(1, 0, 0, 0, 1, i, 'h100 + i, 0, 0, 0, i + 1);
    add(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) add(1, 0, 1, i, 0, 0, 0, 1, 'h100 + i, 1, 0);
    add(1, 0, 1, 3, 1, 3, 'hAAAA, 1, 'h103, 1, 1);
    add(1, 0, 0, 0, 1, 5, 'h5005, 1, 'h103, 0, 2);
    add(1, 1, 0, 0, 0, 0, 0, 0, 'h103, 0, 0);
    add(1, 0, 1, 3, 0, 0, 0, 0, 'hAAAA, 1, 0);
    add(1, 1, 1, 5, 1, 5, 'h55, 1, 'h5005, 1, 0);
    add(1, 0, 1, 5, 0, 0, 0, 1, 'h55, 1, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 'h55, 0, 0);
    add(1, 0, 1, 5, 0, 0, 0, 0, 'h5005, 1, 0);
    add(1, 0, 0, 0, 1, 250, 'hDEAD, 0, 'h5005, 0, 0);
    add(1, 0, 0, 0, 1, 199, 'h199, 0, 'h5005, 0, 1);
    add(1, 0, 0, 0, 1, 200, 'hBEEF, 0, 'h5005, 0, 1);
    add(1, 0, 1, 250, 0, 0, 0, 0, 0, 1, 1);
    add(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 0, 1, 199, 0, 0, 0, 1, 'h199, 1, 0);
    add(1, 0, 1, 200, 0, 0, 0, 1, 0, 1, 0);
    add(1, 0, 1, 0, 0, 0, 0, 1, 'h100, 1, 0);
    add(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 3, 0, 0, 0, 0, 'hAAAA, 1, 0);
    add(1, 0, 0, 0, 1, 0, 'h77, 0, 'hAAAA, 0, 1);
    add(1, 1, 0, 0, 0, 0, 0, 1, 'hAAAA, 0, 0);
    add(1, 1, 0, 0, 1, 7, 'h7, 0, 'hAAAA, 0, 0);
    add(1, 0, 1, 7, 0, 0, 0, 0, 'h7, 1, 0);
    foreach (vecs[k]) begin
      rst_n = vecs[k].rst_n;
      switch_banks = vecs[k].sw;
      ren = vecs[k].ren;
      radr = vecs[k].radr;
      wen = vecs[k].wen;
      wadr = vecs[k].wadr;
      wdata = vecs[k].wdata;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d rd_bank", k), 64'(rd_bank), 64'(vecs[k].e_bank));
      chk($sformatf("v%0d rdata", k), rdata, vecs[k].e_rdata);
      chk($sformatf("v%0d rdata_valid", k), 64'(rdata_valid), 64'(vecs[k].e_valid));
      chk($sformatf("v%0d wr_count", k), 64'(wr_count), 64'(vecs[k].e_cnt));
    end
    rst_n = 1'b1;
    ren = 1'b0;
    switch_banks = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      wen = 1'b1;
      wadr = AW'(10);
      wdata = DW'(i);
      @(posedge clk);
      #1;
      exp_cnt = (exp_cnt == 256) ? 256 : exp_cnt + 1;
      chk($sformatf("sat%0d wr_count", i), 64'(wr_count), 64'(exp_cnt));
    end
    wen = 1'b0;
    switch_banks = 1'b1;
    @(posedge clk);
    #1;
    chk("sat switch wr_count", 64'(wr_count), 64'd0);
    chk("sat switch rd_bank", 64'(rd_bank), 64'd1);
    switch_banks = 1'b0;
    ren = 1'b1;
    radr = AW'(10);
    @(posedge clk);
    #1;
    chk("sat last word", rdata, 64'd299);
    ren = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
